counter_item_store: RTL
=======================

# counter_item_store

Sequential storage and interaction controller for kitchen counter contents. It consumes the collision block's touching flag and nearest-counter coordinates together with the penguin's interact key. It maps the counter top-left coordinate to a slot index, and on each interact press performs a pick-up or place between the penguin's held item and that slot. It also provides a registered read port so the sprite renderer can draw every counter's item.

## Interface
Parameters:
- TOP_SLOTS, 16, top-row counters: X = 20 + 40k, Y = 100, k = 0..15, slots 0..15
- MID_SLOTS, 9, middle-row counters: X = 20 + 40k, Y = 220, k = 0..8, slots 16..24
- DISP_SLOT, 3, dispenser slot; pick-up never empties it
- DISP_ITEM, 3'd1, item code the dispenser holds after reset

Ports:
- Clk  in  1  system clock; all state changes on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- touchingFlag  in  1  penguin is touching a counter (from collision block)
- counterX  in  10  nearest counter top-left X
- counterY  in  10  nearest counter top-left Y
- interact  in  1  interact key level, synchronous to Clk
- heldItem  in  3  penguin's current item; 0 = empty
- heldLoad  out  1  one-cycle strobe: penguin must load heldNext
- heldNext  out  3  new held item, valid while heldLoad = 1
- busy  out  1  transaction in progress
- readSlot  in  5  renderer slot index
- readItem  out  3  item in readSlot, registered

## Operation
- Storage: 25 x 3-bit slot registers. Code 0 = empty.
- Reset (async, Reset_n = 0):
  - all slots clear to 0, except DISP_SLOT, which loads DISP_ITEM
  - state = IDLE; heldLoad = 0, heldNext = 0, busy = 0, readItem = 0, interact edge register = 0
- Edge detect: the interact edge register updates every cycle. A press is interact = 1 with the previous sample 0.
- States:
  - IDLE: on press with touchingFlag = 1, capture counterX, counterY and heldItem, then go to DECODE. A press with touchingFlag = 0 is dropped; holding the key while walking into a counter does not trigger.
  - DECODE: compute the index. The request is valid only if all of these hold:
    - counterX[9:0] >= 20
    - (counterX - 20) % 40 == 0
    - k = (counterX - 20) / 40
    - Y = 100 with k < 16 gives slot k; Y = 220 with k < 9 gives slot 16 + k; any other Y is invalid
    - Valid goes to ACT. Invalid goes to RELEASE with no slot change and no heldLoad.
  - ACT: let S = slot content and H = captured heldItem.
    - H = 0, S != 0: pick-up. heldNext = S. Slot is cleared, except DISP_SLOT, which keeps its content.
    - H != 0, S = 0: place. Slot = H, heldNext = 0.
    - H != 0, S != 0: no swap, no change, no heldLoad.
    - H = 0, S = 0: no change, no heldLoad.
    - Always goes to RELEASE.
  - RELEASE: wait for interact = 0, then go to IDLE. One transaction per press.
- busy = 1 in DECODE, ACT and RELEASE.
- Inputs are ignored outside IDLE capture. A change to heldItem mid-transaction uses the captured value.
- Read port: readItem <= slot[readSlot] every cycle. readSlot >= 25 returns 0. A read of the slot being written on the same edge returns the old value.

## Timing
- Edge E0: press accepted in IDLE; inputs captured; busy = 1 after E0.
- Edge E1: DECODE resolves to ACT or RELEASE.
- Edge E2: ACT commits the slot write and registers heldLoad = 1 with heldNext.
- Edge E3: heldLoad returns to 0. heldLoad is exactly one cycle wide.
- Fastest return to IDLE is edge E3, if interact is already 0. busy = 0 after the edge that enters IDLE.
- A readSlot request made at or after E2 sees the new value one cycle later.
- Minimum spacing between accepted presses: 4 cycles.
- Reset asserted mid-transaction: immediate return to reset state; a pending heldLoad is cancelled.

## Test plan
- Reset, then readSlot sweep 0..31: slot 3 reads 1; all other slots read 0, including out-of-range indices 25..31.
- Place: touching, X = 60, Y = 100, heldItem = 2, one press. Expect heldLoad = 1 with heldNext = 0 exactly at E2..E3; slot 1 then reads 2.
- Pick-up and dispenser: from the previous state, a press at slot 1 with heldItem = 0 gives heldNext = 2 and slot 1 becomes 0. A press at X = 140, Y = 100 gives heldNext = 1 and slot 3 stays 1.
- Invalid and guarded cases: all produce no heldLoad and no slot change.
  - X = 380, Y = 220 (k = 9, out of range)
  - X = 50, Y = 100 (not aligned)
  - Y = 160
  - press with touchingFlag = 0, then touchingFlag raised while the key is still held
  - both items full: slot 1 = 2, heldItem = 4
- Hold interact for 20 cycles: exactly one transaction; busy stays 1 until the cycle after release. A second press 1 cycle after release is accepted.
- Assert Reset_n = 0 in ACT: no heldLoad pulse, slot unchanged from its reset value, state IDLE.

Source files
------------

// File: rtl/counter_item_store.sv
// Kitchen counter item storage: maps the touched counter to a slot and performs
// one pick-up or place per interact press, with a registered read port for the renderer.
module counter_item_store #(
    parameter int         TOP_SLOTS = 16,
    parameter int         MID_SLOTS = 9,
    parameter int         DISP_SLOT = 3,
    parameter logic [2:0] DISP_ITEM = 3'd1
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       touchingFlag,
    input  logic [9:0] counterX,
    input  logic [9:0] counterY,
    input  logic       interact,
    input  logic [2:0] heldItem,
    output logic       heldLoad,
    output logic [2:0] heldNext,
    output logic       busy,
    input  logic [4:0] readSlot,
    output logic [2:0] readItem
);

    localparam int         NUM_SLOTS   = TOP_SLOTS + MID_SLOTS;
    localparam logic [4:0] NUM_SLOTS_L = 5'(NUM_SLOTS);
    localparam logic [4:0] DISP_IDX    = 5'(DISP_SLOT);
    localparam logic [4:0] MID_BASE    = 5'(TOP_SLOTS);

    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        ACT,
        RELEASE
    } state_t;

    state_t     state;
    logic       interactPrev;
    logic [9:0] capX;
    logic [9:0] capY;
    logic [2:0] capHeld;
    logic [4:0] slotIdx;
    logic [2:0] slots [0:NUM_SLOTS-1];

    logic       press;
    logic [9:0] xOff;
    logic [9:0] kVal;
    logic [9:0] xRem;
    logic       decValid;
    logic [4:0] decIdx;
    logic [2:0] curSlot;

    assign press   = interact & ~interactPrev;
    assign curSlot = slots[slotIdx];

    // Counters sit on a 40-pixel pitch starting at X = 20; only two rows exist.
    always_comb begin
        xOff     = capX - 10'd20;
        kVal     = xOff / 10'd40;
        xRem     = xOff % 10'd40;
        decValid = 1'b0;
        decIdx   = 5'd0;
        if (capX >= 10'd20 && xRem == 10'd0) begin
            if (capY == 10'd100 && kVal < 10'(TOP_SLOTS)) begin
                decValid = 1'b1;
                decIdx   = kVal[4:0];
            end else if (capY == 10'd220 && kVal < 10'(MID_SLOTS)) begin
                decValid = 1'b1;
                decIdx   = kVal[4:0] + MID_BASE;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state        <= IDLE;
            interactPrev <= 1'b0;
            capX         <= 10'd0;
            capY         <= 10'd0;
            capHeld      <= 3'd0;
            slotIdx      <= 5'd0;
            heldLoad     <= 1'b0;
            heldNext     <= 3'd0;
            busy         <= 1'b0;
            readItem     <= 3'd0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slots[i] <= (i == DISP_SLOT) ? DISP_ITEM : 3'd0;
            end
        end else begin
            interactPrev <= interact;
            heldLoad     <= 1'b0;
            // Read happens before this edge's write lands, so a same-edge read sees the old value.
            readItem     <= (readSlot < NUM_SLOTS_L) ? slots[readSlot] : 3'd0;

            case (state)
                IDLE: begin
                    if (press && touchingFlag) begin
                        capX    <= counterX;
                        capY    <= counterY;
                        capHeld <= heldItem;
                        busy    <= 1'b1;
                        state   <= DECODE;
                    end
                end
                DECODE: begin
                    if (decValid) begin
                        slotIdx <= decIdx;
                        state   <= ACT;
                    end else begin
                        state <= RELEASE;
                    end
                end
                ACT: begin
                    if (capHeld == 3'd0 && curSlot != 3'd0) begin
                        heldLoad <= 1'b1;
                        heldNext <= curSlot;
                        if (slotIdx != DISP_IDX) begin
                            slots[slotIdx] <= 3'd0;
                        end
                    end else if (capHeld != 3'd0 && curSlot == 3'd0) begin
                        heldLoad       <= 1'b1;
                        heldNext       <= 3'd0;
                        slots[slotIdx] <= capHeld;
                    end
                    state <= RELEASE;
                end
                RELEASE: begin
                    if (!interact) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
